// File: rtl/aib_avmm_cmd_bridge.sv
// rtl/aib_avmm_cmd_bridge.sv - buffered register-command to AVMM master bridge
//
// Purpose: queues register commands from a valid/ready source in a small FIFO
// and issues them one at a time as AVMM reads/writes. Read data returns on a
// valid/ready response port. Waitrequest and rdatavalid timeouts keep a dead
// slave from hanging the config path.
//
// Ports:
//   avmm_clk, avmm_rst         clock, synchronous active-high reset
//   i_req_* / o_req_ready      command input (write flag, addr, wdata, byte_en)
//   o_rsp_* / i_rsp_ready      read response (rdata, err on timeout)
//   o_wr_timeout               sticky flag: a write was dropped on timeout
//   o_fifo_count               number of buffered commands
//   o_avmm_* / i_avmm_*        AVMM master interface

module aib_avmm_cmd_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          avmm_clk,
  input  logic                          avmm_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_write,
  input  logic [ADDR_WIDTH-1:0]         i_req_addr,
  input  logic [31:0]                   i_req_wdata,
  input  logic [3:0]                    i_req_byte_en,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [31:0]                   o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic                          o_wr_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_avmm_write,
  output logic                          o_avmm_read,
  output logic [ADDR_WIDTH-1:0]         o_avmm_addr,
  output logic [31:0]                   o_avmm_wdata,
  output logic [3:0]                    o_avmm_byte_en,
  input  logic [31:0]                   i_avmm_rdata,
  input  logic                          i_avmm_rdatavalid,
  input  logic                          i_avmm_waitrequest
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 1 + ADDR_WIDTH + 32 + 4;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} state_t;

  state_t                state_q;
  logic [EW-1:0]         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [TW-1:0]         timer_q;
  logic                  cmd_write_q;
  logic                  avmm_write_q, avmm_read_q;
  logic [ADDR_WIDTH-1:0] avmm_addr_q;
  logic [31:0]           avmm_wdata_q;
  logic [3:0]            avmm_byte_en_q;
  logic                  rsp_valid_q, rsp_err_q, wr_timeout_q;
  logic [31:0]           rsp_rdata_q;

  logic                  push, pop;
  logic [EW-1:0]         head;

  assign o_req_ready = (count_q != FULL);
  assign push        = i_req_valid & o_req_ready;
  // Pop only while idle, so nothing new issues while a response is pending.
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst && push) begin
      fifo_q[wr_ptr_q] <= {i_req_write, i_req_addr, i_req_wdata, i_req_byte_en};
    end
  end

  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      cmd_write_q    <= 1'b0;
      avmm_write_q   <= 1'b0;
      avmm_read_q    <= 1'b0;
      avmm_addr_q    <= '0;
      avmm_wdata_q   <= '0;
      avmm_byte_en_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      wr_timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_write_q    <= head[EW-1];
            avmm_addr_q    <= head[36 +: ADDR_WIDTH];
            avmm_wdata_q   <= head[35:4];
            avmm_byte_en_q <= head[3:0];
            avmm_write_q   <= head[EW-1];
            avmm_read_q    <= ~head[EW-1];
            timer_q        <= '0;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i_avmm_waitrequest) begin
            avmm_write_q <= 1'b0;
            avmm_read_q  <= 1'b0;
            timer_q      <= '0;
            if (cmd_write_q) begin
              state_q <= IDLE;
            end else if (i_avmm_rdatavalid) begin
              // Zero-latency slave: data arrives with the accept.
              rsp_rdata_q <= i_avmm_rdata;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end else begin
              state_q <= WAIT_RD;
            end
          end else if (timer_q == TMAX) begin
            avmm_write_q <= 1'b0;
            avmm_read_q  <= 1'b0;
            if (cmd_write_q) begin
              wr_timeout_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_RD: begin
          // Data beats expiry when both land in the same cycle.
          if (i_avmm_rdatavalid) begin
            rsp_rdata_q <= i_avmm_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (timer_q == TMAX) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_rdata    = rsp_rdata_q;
  assign o_rsp_err      = rsp_err_q;
  assign o_wr_timeout   = wr_timeout_q;
  assign o_fifo_count   = count_q;
  assign o_avmm_write   = avmm_write_q;
  assign o_avmm_read    = avmm_read_q;
  assign o_avmm_addr    = avmm_addr_q;
  assign o_avmm_wdata   = avmm_wdata_q;
  assign o_avmm_byte_en = avmm_byte_en_q;

endmodule
